decode_control_fsm: RTL and testbench

//  Multi-cycle decode/control sequencer placed directly upstream of the register file.
//  - Accepts one 32-bit MIPS instruction per handshake and splits it into fields.
//  - Drives the register-file read/write addresses and the RegWrite strobe.
//  - Sequences execute, memory and writeback while accounting for the register file's 1-cycle registered read.

---
 rtl/decode_control_fsm_if.sv | 34 +++
 rtl/decode_control_fsm.sv | 195 +++++++++++++++++++
 tb/tb_decode_control_fsm.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/decode_control_fsm_if.sv
// Handshake and register-file/memory control bundle between the instruction source and the decode sequencer.
// Pure wiring: no storage, so it adds no latency.
// Backpressure rides on instr_ready; memory completion arrives on mem_done.
interface decode_control_fsm_if;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [4:0]  read_reg1;
    logic [4:0]  read_reg2;
    logic [4:0]  write_reg;
    logic        RegWrite;
    logic [2:0]  alu_op;
    logic        alu_src;
    logic [31:0] imm_ext;
    logic        mem_read;
    logic        mem_write;
    logic        mem_done;
    logic        mem_to_reg;
    logic        illegal;

    // Instruction source / memory side.
    modport master (
        output instr_valid, instr, mem_done,
        input  instr_ready, read_reg1, read_reg2, write_reg, RegWrite, alu_op,
               alu_src, imm_ext, mem_read, mem_write, mem_to_reg, illegal
    );

    // Sequencer side.
    modport slave (
        input  instr_valid, instr, mem_done,
        output instr_ready, read_reg1, read_reg2, write_reg, RegWrite, alu_op,
               alu_src, imm_ext, mem_read, mem_write, mem_to_reg, illegal
    );
endinterface

// File: rtl/decode_control_fsm.sv
// Multi-cycle MIPS decode/control sequencer feeding a register file with a registered read port.
// Latency: RegWrite fires 4 cycles after the accept edge for ALU ops; lw adds one cycle per MEM cycle.
// Backpressure: instr_ready is high only in IDLE, so at most one instruction is in flight.
// Optional MEM_TIMEOUT_EN: bounds the MEM wait to MEM_TIMEOUT cycles, then flags illegal and abandons.
module decode_control_fsm
`ifdef MEM_TIMEOUT_EN
#(
    parameter int MEM_TIMEOUT = 16
)
`endif
(
    input  logic                 clock,
    input  logic                 reset,
    decode_control_fsm_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DECODE = 3'd1,
        S_READ   = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] instr_q, instr_d;

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
    logic [CNT_W-1:0] mem_cnt_q, mem_cnt_d;
`endif

    // Instruction fields; the latched word stays put from DECODE back to IDLE,
    // which keeps the register addresses stable for the whole instruction.
    logic [5:0] op;
    logic [5:0] funct;
    assign op    = instr_q[31:26];
    assign funct = instr_q[5:0];

    logic       legal;
    logic       is_r;
    logic       is_lw;
    logic       is_sw;
    logic       is_beq;
    logic       zext;
    logic [2:0] alu_op_w;
    logic       alu_src_w;

    // Opcode/funct decode of the latched instruction.
    always_comb begin
        legal     = 1'b0;
        is_r      = 1'b0;
        is_lw     = 1'b0;
        is_sw     = 1'b0;
        is_beq    = 1'b0;
        zext      = 1'b0;
        alu_op_w  = 3'd0;
        alu_src_w = 1'b0;
        case (op)
            6'b000000: begin
                is_r = 1'b1;
                case (funct)
                    6'b100000: begin legal = 1'b1; alu_op_w = 3'd0; end
                    6'b100010: begin legal = 1'b1; alu_op_w = 3'd1; end
                    6'b100100: begin legal = 1'b1; alu_op_w = 3'd2; end
                    6'b100101: begin legal = 1'b1; alu_op_w = 3'd3; end
                    6'b101010: begin legal = 1'b1; alu_op_w = 3'd4; end
                    default:   legal = 1'b0;
                endcase
            end
            6'b001000: begin legal = 1'b1; alu_src_w = 1'b1; alu_op_w = 3'd0; end
            6'b001100: begin legal = 1'b1; alu_src_w = 1'b1; alu_op_w = 3'd2; zext = 1'b1; end
            6'b001101: begin legal = 1'b1; alu_src_w = 1'b1; alu_op_w = 3'd3; zext = 1'b1; end
            6'b100011: begin legal = 1'b1; alu_src_w = 1'b1; is_lw = 1'b1; end
            6'b101011: begin legal = 1'b1; alu_src_w = 1'b1; is_sw = 1'b1; end
            6'b000100: begin legal = 1'b1; alu_op_w = 3'd1; is_beq = 1'b1; end
            default:   legal = 1'b0;
        endcase
    end

    assign bus.read_reg1   = instr_q[25:21];
    assign bus.read_reg2   = instr_q[20:16];
    assign bus.write_reg   = is_r ? instr_q[15:11] : instr_q[20:16];
    assign bus.alu_op      = alu_op_w;
    assign bus.alu_src     = alu_src_w;
    assign bus.imm_ext     = zext ? {16'h0000, instr_q[15:0]} : {{16{instr_q[15]}}, instr_q[15:0]};
    assign bus.instr_ready = (state_q == S_IDLE);

    logic reg_write_w;
    logic mem_read_w;
    logic mem_write_w;
    logic mem_to_reg_w;
    logic illegal_w;

    // Next-state sequencing and per-state control strobes.
    always_comb begin
        state_d      = state_q;
        instr_d      = instr_q;
        reg_write_w  = 1'b0;
        mem_read_w   = 1'b0;
        mem_write_w  = 1'b0;
        mem_to_reg_w = 1'b0;
        illegal_w    = 1'b0;
`ifdef MEM_TIMEOUT_EN
        mem_cnt_d    = '0;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.instr_valid) begin
                    instr_d = bus.instr;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (!legal) begin
                    illegal_w = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    state_d = S_READ;
                end
            end
            // Register file captures the read data at the end of this cycle.
            S_READ: state_d = S_EXEC;
            S_EXEC: begin
                if (is_lw || is_sw) begin
                    state_d = S_MEM;
                end else if (is_beq) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
`ifdef MEM_TIMEOUT_EN
                // After MEM_TIMEOUT strobed cycles without mem_done, one extra
                // cycle drops the strobes and flags the abandoned access.
                if (mem_cnt_q == CNT_W'(MEM_TIMEOUT)) begin
                    illegal_w = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    mem_cnt_d   = mem_cnt_q + 1'b1;
                    mem_read_w  = is_lw;
                    mem_write_w = is_sw;
                    if (bus.mem_done) begin
                        state_d = is_lw ? S_WB : S_IDLE;
                    end
                end
`else
                mem_read_w  = is_lw;
                mem_write_w = is_sw;
                if (bus.mem_done) begin
                    state_d = is_lw ? S_WB : S_IDLE;
                end
`endif
            end
            S_WB: begin
                // Writes to $0 are architecturally discarded.
                reg_write_w  = (bus.write_reg != 5'd0);
                mem_to_reg_w = is_lw;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.RegWrite   = reg_write_w;
    assign bus.mem_read   = mem_read_w;
    assign bus.mem_write  = mem_write_w;
    assign bus.mem_to_reg = mem_to_reg_w;
    assign bus.illegal    = illegal_w;

    // State and instruction register; reset abandons any instruction in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            instr_q <= 32'h0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
        end
    end

`ifdef MEM_TIMEOUT_EN
    // MEM wait counter; cleared whenever the sequencer is outside MEM.
    always_ff @(posedge clock) begin
        if (reset) begin
            mem_cnt_q <= '0;
        end else begin
            mem_cnt_q <= mem_cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_decode_control_fsm.sv
module tb_decode_control_fsm;

    localparam int K_ILL = 0;
    localparam int K_ALU = 1;
    localparam int K_LW  = 2;
    localparam int K_SW  = 3;
    localparam int K_BEQ = 4;
    localparam int TMO   = 16;

    typedef struct packed {
        logic [7:0]  kind;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  dest;
        logic [2:0]  aop;
        logic        asrc;
        logic [31:0] imm;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clock = ~clock;

    decode_control_fsm_if bus();

    decode_control_fsm dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // Reference decode, straight from the instruction-set table.
    function automatic exp_t model(input logic [31:0] w);
        exp_t e;
        e      = '0;
        e.rs   = w[25:21];
        e.rt   = w[20:16];
        e.dest = (w[31:26] == 6'd0) ? w[15:11] : w[20:16];
        e.imm  = {{16{w[15]}}, w[15:0]};
        e.kind = 8'(K_ILL);
        case (int'(w[31:26]))
            0: case (int'(w[5:0]))
                   32: begin e.kind = 8'(K_ALU); e.aop = 3'd0; end
                   34: begin e.kind = 8'(K_ALU); e.aop = 3'd1; end
                   36: begin e.kind = 8'(K_ALU); e.aop = 3'd2; end
                   37: begin e.kind = 8'(K_ALU); e.aop = 3'd3; end
                   42: begin e.kind = 8'(K_ALU); e.aop = 3'd4; end
                   default: e.kind = 8'(K_ILL);
               endcase
            8:  begin e.kind = 8'(K_ALU); e.asrc = 1'b1; e.aop = 3'd0; end
            12: begin e.kind = 8'(K_ALU); e.asrc = 1'b1; e.aop = 3'd2; e.imm = {16'h0, w[15:0]}; end
            13: begin e.kind = 8'(K_ALU); e.asrc = 1'b1; e.aop = 3'd3; e.imm = {16'h0, w[15:0]}; end
            35: begin e.kind = 8'(K_LW);  e.asrc = 1'b1; end
            43: begin e.kind = 8'(K_SW);  e.asrc = 1'b1; end
            4:  begin e.kind = 8'(K_BEQ); e.aop = 3'd1; end
            default: e.kind = 8'(K_ILL);
        endcase
        return e;
    endfunction

    // Drive one instruction through and check every cycle until IDLE is back.
    // n = MEM cycle in which mem_done is raised (memory ops only, n >= 1).
    task automatic run_instr(input logic [31:0] w, input int n);
        exp_t e;
        int   kind;
        int   total;
        logic exp_rdy, exp_rw, exp_mr, exp_mw, exp_m2r, exp_ill;
        e    = model(w);
        kind = int'(e.kind);
        case (kind)
            K_ILL:   total = 1;
            K_BEQ:   total = 3;
            K_ALU:   total = 4;
            K_SW:    total = 3 + n;
            default: total = 4 + n;
        endcase
        @(negedge clock);
        n_vec++;
        if (bus.instr_ready !== 1'b1) begin
            n_err++; $display("FAIL ready_before w=%h got %b want 1", w, bus.instr_ready);
        end
        bus.instr_valid = 1'b1;
        bus.instr       = w;
        bus.mem_done    = 1'b0;
        for (int k = 1; k <= total + 1; k++) begin
            @(negedge clock);
            if (k < total) begin
                bus.instr_valid = 1'b1;
                bus.instr       = $urandom;
            end else begin
                bus.instr_valid = 1'b0;
            end
            if ((kind == K_LW || kind == K_SW) && k >= 4 && k <= 3 + n)
                bus.mem_done = (k == 3 + n);
            else
                bus.mem_done = 1'($urandom_range(0, 1));
            exp_rdy = (k > total);
            exp_rw  = (e.dest != 5'd0) &&
                      ((kind == K_ALU && k == 4) || (kind == K_LW && k == 4 + n));
            exp_mr  = (kind == K_LW) && k >= 4 && k <= 3 + n;
            exp_mw  = (kind == K_SW) && k >= 4 && k <= 3 + n;
            exp_m2r = (kind == K_LW) && k == 4 + n;
            exp_ill = (kind == K_ILL) && k == 1;
            n_vec += 6;
            if (bus.instr_ready !== exp_rdy) begin
                n_err++; $display("FAIL instr_ready w=%h k=%0d got %b want %b", w, k, bus.instr_ready, exp_rdy);
            end
            if (bus.RegWrite !== exp_rw) begin
                n_err++; $display("FAIL RegWrite w=%h k=%0d got %b want %b", w, k, bus.RegWrite, exp_rw);
            end
            if (bus.mem_read !== exp_mr) begin
                n_err++; $display("FAIL mem_read w=%h k=%0d got %b want %b", w, k, bus.mem_read, exp_mr);
            end
            if (bus.mem_write !== exp_mw) begin
                n_err++; $display("FAIL mem_write w=%h k=%0d got %b want %b", w, k, bus.mem_write, exp_mw);
            end
            if (bus.mem_to_reg !== exp_m2r) begin
                n_err++; $display("FAIL mem_to_reg w=%h k=%0d got %b want %b", w, k, bus.mem_to_reg, exp_m2r);
            end
            if (bus.illegal !== exp_ill) begin
                n_err++; $display("FAIL illegal w=%h k=%0d got %b want %b", w, k, bus.illegal, exp_ill);
            end
            if (kind != K_ILL && k <= total) begin
                n_vec += 6;
                if (bus.read_reg1 !== e.rs) begin
                    n_err++; $display("FAIL read_reg1 w=%h k=%0d got %0d want %0d", w, k, bus.read_reg1, e.rs);
                end
                if (bus.read_reg2 !== e.rt) begin
                    n_err++; $display("FAIL read_reg2 w=%h k=%0d got %0d want %0d", w, k, bus.read_reg2, e.rt);
                end
                if (bus.write_reg !== e.dest) begin
                    n_err++; $display("FAIL write_reg w=%h k=%0d got %0d want %0d", w, k, bus.write_reg, e.dest);
                end
                if (bus.alu_op !== e.aop) begin
                    n_err++; $display("FAIL alu_op w=%h k=%0d got %0d want %0d", w, k, bus.alu_op, e.aop);
                end
                if (bus.alu_src !== e.asrc) begin
                    n_err++; $display("FAIL alu_src w=%h k=%0d got %b want %b", w, k, bus.alu_src, e.asrc);
                end
                if (bus.imm_ext !== e.imm) begin
                    n_err++; $display("FAIL imm_ext w=%h k=%0d got %h want %h", w, k, bus.imm_ext, e.imm);
                end
            end
        end
    endtask

    task automatic test_reset();
        reset           = 1'b1;
        bus.instr_valid = 1'b1;
        bus.instr       = 32'h02B60820;
        bus.mem_done    = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        n_vec += 7;
        if (bus.instr_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got %b want 1", bus.instr_ready); end
        if (bus.RegWrite !== 1'b0)    begin n_err++; $display("FAIL reset_regwrite got %b want 0", bus.RegWrite); end
        if (bus.illegal !== 1'b0)     begin n_err++; $display("FAIL reset_illegal got %b want 0", bus.illegal); end
        if (bus.read_reg1 !== 5'd0)   begin n_err++; $display("FAIL reset_rr1 got %0d want 0", bus.read_reg1); end
        if (bus.read_reg2 !== 5'd0)   begin n_err++; $display("FAIL reset_rr2 got %0d want 0", bus.read_reg2); end
        if (bus.write_reg !== 5'd0)   begin n_err++; $display("FAIL reset_wr got %0d want 0", bus.write_reg); end
        if (bus.mem_read !== 1'b0 || bus.mem_write !== 1'b0 || bus.imm_ext !== 32'h0) begin
            n_err++; $display("FAIL reset_mem got %b%b %h want 00 0", bus.mem_read, bus.mem_write, bus.imm_ext);
        end
        bus.instr_valid = 1'b0;
        bus.mem_done    = 1'b0;
        reset           = 1'b0;
    endtask

    task automatic test_directed();
        run_instr(32'h02B60820, 1);   // add $1,$21,$22
        run_instr(32'h8C220004, 3);   // lw $2,4($1), three MEM cycles
        run_instr(32'h8C220004, 1);   // lw with immediate mem_done
        run_instr(32'h3403FFFF, 1);   // ori, zero-extended
        run_instr(32'h2003FFFF, 1);   // addi, sign-extended
        run_instr(32'h3003_8000, 1);  // andi, zero-extended
        run_instr(32'h00000020, 1);   // add $0: WB with write suppressed
        run_instr(32'hFC000000, 1);   // illegal opcode
        run_instr(32'h00221821 & 32'hFFFF_FFC0, 1); // R-type funct 0: illegal
        run_instr(32'hAC220008, 2);   // sw
        run_instr(32'h1022FFFE, 1);   // beq
        run_instr(32'h0022182A, 1);   // slt
    endtask

    task automatic test_reset_mid();
        @(negedge clock);
        bus.instr_valid = 1'b1;
        bus.instr       = 32'h02B60820;
        @(negedge clock);             // DECODE
        bus.instr_valid = 1'b0;
        @(negedge clock);             // READ
        @(negedge clock);             // EXEC
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            reset = 1'b0;
            n_vec += 3;
            if (bus.instr_ready !== 1'b1) begin n_err++; $display("FAIL midrst_ready k=%0d got %b want 1", k, bus.instr_ready); end
            if (bus.RegWrite !== 1'b0)    begin n_err++; $display("FAIL midrst_regwrite k=%0d got %b want 0", k, bus.RegWrite); end
            if (bus.write_reg !== 5'd0)   begin n_err++; $display("FAIL midrst_wr k=%0d got %0d want 0", k, bus.write_reg); end
        end
    endtask

    task automatic test_random();
        logic [31:0] w;
        int          sel;
        int          fn [5] = '{32, 34, 36, 37, 42};
        int          ops[6] = '{8, 12, 13, 35, 43, 4};
        for (int i = 0; i < 300; i++) begin
            w   = $urandom;
            sel = $urandom_range(0, 11);
            if (sel < 5)       w = {6'd0, w[25:6], 6'(fn[sel])};
            else if (sel < 11) w = {6'(ops[sel - 5]), w[25:0]};
            run_instr(w, $urandom_range(1, 5));
        end
    endtask

`ifdef MEM_TIMEOUT_EN
    task automatic test_timeout();
        logic exp_mw, exp_ill, exp_rdy;
        @(negedge clock);
        bus.instr_valid = 1'b1;
        bus.instr       = 32'hAC220008;
        bus.mem_done    = 1'b0;
        for (int k = 1; k <= TMO + 5; k++) begin
            @(negedge clock);
            bus.instr_valid = 1'b0;
            exp_mw  = (k >= 4 && k <= 3 + TMO);
            exp_ill = (k == 4 + TMO);
            exp_rdy = (k > 4 + TMO);
            n_vec += 4;
            if (bus.mem_write !== exp_mw)  begin n_err++; $display("FAIL tmo_mem_write k=%0d got %b want %b", k, bus.mem_write, exp_mw); end
            if (bus.illegal !== exp_ill)   begin n_err++; $display("FAIL tmo_illegal k=%0d got %b want %b", k, bus.illegal, exp_ill); end
            if (bus.instr_ready !== exp_rdy) begin n_err++; $display("FAIL tmo_ready k=%0d got %b want %b", k, bus.instr_ready, exp_rdy); end
            if (bus.RegWrite !== 1'b0)     begin n_err++; $display("FAIL tmo_regwrite k=%0d got %b want 0", k, bus.RegWrite); end
        end
    endtask
`endif

    initial begin
        bus.instr_valid = 1'b0;
        bus.instr       = 32'h0;
        bus.mem_done    = 1'b0;
        test_reset();
        test_directed();
        test_reset_mid();
        test_random();
`ifdef MEM_TIMEOUT_EN
        test_timeout();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
